// File: rtl/rv_wb_arbiter.sv
// Two-master (fetch / load-store) to single Wishbone master arbiter with fetch anti-starvation.
// Optional bus timeout enabled by defining RV_WB_ARB_TIMEOUT_EN.
module rv_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  output logic        o_instr_ack,
  output logic [31:0] o_instr_data,
  input  logic        i_data_req,
  input  logic        i_data_write,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_sel,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  output logic        o_bus_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rv_wb_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;

  logic busy;
  logic timeout;
  logic done;

  assign busy = (state_q == INSTR) || (state_q == DATA);
  assign done = busy && (i_wb_ack || timeout);

`ifdef RV_WB_ARB_TIMEOUT_EN
  localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // An ack arriving on the terminal count wins over the timeout.
  assign timeout = busy && !i_wb_ack && (cnt_q == LastCount);

  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!i_wb_ack) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        // A pending fetch-priority flag overrides the default data-first order.
        if (i_instr_req && (prio_q || !i_data_req)) begin
          state_d = INSTR;
          prio_d  = 1'b0;
          cyc_d   = 1'b1;
          adr_d   = i_instr_addr;
          dat_d   = '0;
          sel_d   = '1;
          we_d    = 1'b0;
        end else if (i_data_req) begin
          state_d = DATA;
          cyc_d   = 1'b1;
          adr_d   = i_data_addr;
          dat_d   = i_data_wdata;
          sel_d   = i_data_sel;
          we_d    = i_data_write;
        end
      end
      INSTR, DATA: begin
        if (state_q == DATA && i_instr_req) begin
          prio_d = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

  assign o_wb_cyc = cyc_q;
  assign o_wb_stb = cyc_q;
  assign o_wb_adr = adr_q;
  assign o_wb_dat = dat_q;
  assign o_wb_sel = sel_q;
  assign o_wb_we  = we_q;

  assign o_instr_ack  = (state_q == INSTR) && done;
  assign o_data_ack   = (state_q == DATA) && done;
  assign o_instr_data = timeout ? '0 : i_wb_dat;
  assign o_data_rdata = timeout ? '0 : i_wb_dat;
  assign o_bus_err    = timeout;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Scoreboard bench for rv_wb_arbiter: requester tasks push expectations, a negedge monitor pops them on acks.
module tb_rv_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_instr_req = 1'b0;
  logic [31:0] i_instr_addr = '0;
  logic        o_instr_ack;
  logic [31:0] o_instr_data;
  logic        i_data_req = 1'b0;
  logic        i_data_write = 1'b0;
  logic [31:0] i_data_addr = '0;
  logic [31:0] i_data_wdata = '0;
  logic [3:0]  i_data_sel = '0;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic        o_wb_stb;
  logic        o_wb_cyc;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_ack = 1'b0;
  logic        o_bus_err;

  rv_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_ack(o_instr_ack), .o_instr_data(o_instr_data),
    .i_data_req(i_data_req), .i_data_write(i_data_write), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .i_data_sel(i_data_sel),
    .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_stb(o_wb_stb), .o_wb_cyc(o_wb_cyc),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        berr;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  logic grant_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int unsigned slave_wait = 0;
  int unsigned wcnt = 0;
  bit          slave_en = 1'b1;
  bit          stray_ack = 1'b0;

  function automatic logic [31:0] sd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'h1);
  endfunction

  // Slave model: acks after slave_wait wait states, reacts 1 time unit after each rising edge.
  always @(posedge i_clk) begin
    #1;
    if (o_wb_cyc && o_wb_stb && slave_en && !i_wb_ack) begin
      if (wcnt >= slave_wait) begin
        i_wb_ack = 1'b1;
        i_wb_dat = sd(o_wb_adr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      i_wb_ack = stray_ack;
      i_wb_dat = stray_ack ? 32'hBAD0_BAD0 : 32'h0;
      wcnt = 0;
    end
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset_n && (o_instr_ack || o_data_ack)) begin
      n_tests++;
      if (o_instr_ack && o_data_ack) begin
        n_fail++; $display("FAIL mon_both_acks got instr=%b data=%b exp one", o_instr_ack, o_data_ack);
      end
      n_tests++;
      if (o_wb_cyc !== 1'b1) begin
        n_fail++; $display("FAIL mon_ack_without_cyc got cyc=%b exp 1", o_wb_cyc);
      end
      if (o_instr_ack) begin
        grant_log.push_back(1'b0);
        n_tests++;
        if (iq.size() == 0) begin
          n_fail++; $display("FAIL mon_unexpected_instr_ack got ack with adr=%h exp none", o_wb_adr);
        end else begin
          e = iq.pop_front();
          n_tests += 4;
          if (o_wb_adr !== e.adr) begin n_fail++; $display("FAIL mon_instr_adr got %h exp %h", o_wb_adr, e.adr); end
          if ({o_wb_we, o_wb_sel} !== {1'b0, 4'hF}) begin
            n_fail++; $display("FAIL mon_instr_we_sel got we=%b sel=%h exp we=0 sel=f", o_wb_we, o_wb_sel);
          end
          if (o_instr_data !== e.rdat) begin n_fail++; $display("FAIL mon_instr_data got %h exp %h", o_instr_data, e.rdat); end
          if (o_bus_err !== e.berr) begin n_fail++; $display("FAIL mon_instr_berr got %b exp %b", o_bus_err, e.berr); end
        end
      end
      if (o_data_ack) begin
        grant_log.push_back(1'b1);
        n_tests++;
        if (dq.size() == 0) begin
          n_fail++; $display("FAIL mon_unexpected_data_ack got ack with adr=%h exp none", o_wb_adr);
        end else begin
          e = dq.pop_front();
          n_tests += 5;
          if (o_wb_adr !== e.adr) begin n_fail++; $display("FAIL mon_data_adr got %h exp %h", o_wb_adr, e.adr); end
          if ({o_wb_we, o_wb_sel} !== {e.we, e.sel}) begin
            n_fail++; $display("FAIL mon_data_we_sel got we=%b sel=%h exp we=%b sel=%h", o_wb_we, o_wb_sel, e.we, e.sel);
          end
          if (e.we && o_wb_dat !== e.wdat) begin n_fail++; $display("FAIL mon_data_wdat got %h exp %h", o_wb_dat, e.wdat); end
          if (o_data_rdata !== e.rdat) begin n_fail++; $display("FAIL mon_data_rdata got %h exp %h", o_data_rdata, e.rdat); end
          if (o_bus_err !== e.berr) begin n_fail++; $display("FAIL mon_data_berr got %b exp %b", o_bus_err, e.berr); end
        end
      end
    end
  end

  task automatic sync();
    @(posedge i_clk); #1;
  endtask

  task automatic instr_xfer(input logic [31:0] a, input logic [31:0] rd, input logic berr);
    exp_t e;
    bit got = 1'b0;
    e = '{adr: a, we: 1'b0, sel: 4'hF, wdat: 32'h0, rdat: rd, berr: berr};
    iq.push_back(e);
    i_instr_req = 1'b1;
    i_instr_addr = a;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge i_clk);
      if (o_instr_ack) got = 1'b1;
    end
    sync();
    i_instr_req = 1'b0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL instr_xfer_timeout got no ack for %h exp ack within 64 cycles", a); end
  endtask

  task automatic data_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] sel, input logic [31:0] rd, input logic berr);
    exp_t e;
    bit got = 1'b0;
    e = '{adr: a, we: we, sel: sel, wdat: wd, rdat: rd, berr: berr};
    dq.push_back(e);
    i_data_req = 1'b1;
    i_data_write = we;
    i_data_addr = a;
    i_data_wdata = wd;
    i_data_sel = sel;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge i_clk);
      if (o_data_ack) got = 1'b1;
    end
    sync();
    i_data_req = 1'b0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL data_xfer_timeout got no ack for %h exp ack within 64 cycles", a); end
  endtask

  task automatic check_log(input string name, input logic [4:0] exp_bits, input int n);
    n_tests++;
    if (grant_log.size() != n) begin
      n_fail++; $display("FAIL %s_len got %0d exp %0d", name, grant_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (grant_log[i] !== exp_bits[i]) begin
          n_fail++; $display("FAIL %s_order[%0d] got %b exp %b (1=data)", name, i, grant_log[i], exp_bits[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_bus_err, o_instr_ack, o_data_ack} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl got cyc=%b stb=%b we=%b sel=%h err=%b ia=%b da=%b exp all 0",
                         o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_bus_err, o_instr_ack, o_data_ack);
    end
    n_tests++;
    if ({o_wb_adr, o_wb_dat} !== 64'h0) begin
      n_fail++; $display("FAIL reset_adr_dat got adr=%h dat=%h exp 0", o_wb_adr, o_wb_dat);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    sync();
  endtask

  task automatic test_instr_basic();
    slave_wait = 2;
    fork
      instr_xfer(32'h100, 32'h0000_0013, 1'b0);
      begin
        @(negedge i_clk);
        n_tests++;
        if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL basic_cyc_n got %b exp 0", o_wb_cyc); end
        @(negedge i_clk);
        n_tests++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100}) begin
          n_fail++; $display("FAIL basic_bus_n1 got cyc=%b stb=%b we=%b sel=%h adr=%h exp 1 1 0 f 00000100",
                             o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr);
        end
        @(negedge i_clk);
        n_tests++;
        if (o_instr_ack !== 1'b0) begin n_fail++; $display("FAIL basic_early_ack got %b exp 0", o_instr_ack); end
        @(negedge i_clk);
        n_tests++;
        if ({o_instr_ack, o_instr_data} !== {1'b1, 32'h13}) begin
          n_fail++; $display("FAIL basic_ack got ack=%b data=%h exp 1 00000013", o_instr_ack, o_instr_data);
        end
      end
    join
  endtask

  task automatic test_priority();
    slave_wait = 0;
    grant_log.delete();
    fork
      begin
        data_xfer(1'b1, 32'h2000, 32'hA5A5_A5A5, 4'b0011, sd(32'h2000), 1'b0);
        data_xfer(1'b0, 32'h3000, 32'h0, 4'hF, sd(32'h3000), 1'b0);
      end
      instr_xfer(32'h104, sd(32'h104), 1'b0);
    join
    check_log("prio", 5'b00101, 3);
  endtask

  task automatic test_no_starvation();
    slave_wait = 1;
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) begin
        data_xfer(1'b0, 32'h4000 + 32'(i * 4), 32'h0, 4'hF, sd(32'h4000 + 32'(i * 4)), 1'b0);
      end
      for (int j = 0; j < 2; j++) begin
        instr_xfer(32'h200 + 32'(j * 4), sd(32'h200 + 32'(j * 4)), 1'b0);
      end
    join
    check_log("starve", 5'b10101, 5);
  endtask

  task automatic test_drop_req();
    exp_t e;
    slave_wait = 3;
    e = '{adr: 32'h5000, we: 1'b1, sel: 4'b1100, wdat: 32'h1234_5678, rdat: sd(32'h5000), berr: 1'b0};
    dq.push_back(e);
    i_data_req = 1'b1; i_data_write = 1'b1; i_data_addr = 32'h5000;
    i_data_wdata = 32'h1234_5678; i_data_sel = 4'b1100;
    sync();
    i_data_req = 1'b0;
    for (int k = 0; k < 10 && dq.size() != 0; k++) @(negedge i_clk);
    n_tests++;
    if (dq.size() != 0) begin n_fail++; $display("FAIL drop_req_ack got pending=%0d exp 0", dq.size()); end
    repeat (2) @(negedge i_clk);
    n_tests++;
    if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL drop_req_idle got cyc=%b exp 0", o_wb_cyc); end
    sync();
  endtask

  task automatic test_reset_mid();
    slave_wait = 5;
    i_data_req = 1'b1; i_data_write = 1'b1; i_data_addr = 32'h6000;
    i_data_wdata = 32'hFFFF_0000; i_data_sel = 4'hF;
    sync();
    @(negedge i_clk);
    n_tests++;
    if (o_wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got cyc=%b exp 1", o_wb_cyc); end
    #2 i_reset_n = 1'b0;
    #1;
    n_tests++;
    if ({o_wb_cyc, o_wb_stb, o_data_ack, o_instr_ack, o_wb_adr} !== 36'h0) begin
      n_fail++; $display("FAIL rstmid_drop got cyc=%b stb=%b da=%b ia=%b adr=%h exp all 0",
                         o_wb_cyc, o_wb_stb, o_data_ack, o_instr_ack, o_wb_adr);
    end
    i_data_req = 1'b0;
    i_instr_req = 1'b1; i_instr_addr = 32'h108;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    n_tests++;
    if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rstmid_release got cyc=%b exp 0", o_wb_cyc); end
    i_instr_req = 1'b0;
    sync();
    slave_wait = 0;
    instr_xfer(32'h108, sd(32'h108), 1'b0);
  endtask

  task automatic test_stray_ack();
    stray_ack = 1'b1;
    sync();
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      n_tests++;
      if ({i_wb_ack, o_instr_ack, o_data_ack, o_wb_cyc} !== 4'b1000) begin
        n_fail++; $display("FAIL stray_%0d got wb_ack=%b ia=%b da=%b cyc=%b exp 1 0 0 0",
                           k, i_wb_ack, o_instr_ack, o_data_ack, o_wb_cyc);
      end
    end
    stray_ack = 1'b0;
    sync(); sync();
    data_xfer(1'b0, 32'h7000, 32'h0, 4'b0001, sd(32'h7000), 1'b0);
  endtask

`ifdef RV_WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    slave_en = 1'b0;
    fork
      instr_xfer(32'h40, 32'h0, 1'b1);
      begin
        @(negedge i_clk);
        for (int k = 1; k <= 4; k++) begin
          @(negedge i_clk);
          n_tests++;
          if ({o_wb_cyc, o_bus_err, o_instr_ack} !== {1'b1, (k == 4), (k == 4)}) begin
            n_fail++; $display("FAIL timeout_cyc%0d got cyc=%b err=%b ack=%b exp 1 %b %b",
                               k, o_wb_cyc, o_bus_err, o_instr_ack, (k == 4), (k == 4));
          end
        end
      end
    join
    slave_en = 1'b1;
    slave_wait = 3;
    instr_xfer(32'h44, sd(32'h44), 1'b0);
  endtask
`else
  task automatic test_timeout();
    bit bad = 1'b0;
    slave_en = 1'b0;
    i_instr_req = 1'b1; i_instr_addr = 32'h40;
    sync();
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if ({o_wb_cyc, o_instr_ack, o_bus_err} !== 3'b100) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL notimeout_hold got cyc=%b ack=%b err=%b exp 1 0 0", o_wb_cyc, o_instr_ack, o_bus_err); end
    i_reset_n = 1'b0;
    i_instr_req = 1'b0;
    slave_en = 1'b1;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    sync();
    instr_xfer(32'h48, sd(32'h48), 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_instr_basic();
    test_priority();
    test_no_starvation();
    test_drop_req();
    test_reset_mid();
    test_stray_ack();
    test_timeout();
    repeat (3) @(negedge i_clk);
    n_tests++;
    if (iq.size() + dq.size() != 0) begin
      n_fail++; $display("FAIL leftover_expectations got %0d exp 0", iq.size() + dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
